// File: rtl/io_pkg.sv
// Shared types and constants for the I/O bridge: read-source select,
// interrupt-controller register offsets and the default I/O base.
package io_pkg;

    typedef enum logic [1:0] {
        SEL_MEM,
        SEL_DEV,
        SEL_IRQC,
        SEL_NONE
    } rd_sel_e;

    localparam int IRQ_PENDING = 0;
    localparam int IRQ_MASK    = 1;
    localparam int IRQ_RAW     = 2;

    localparam logic [17:0] IO_BASE_DEFAULT = 18'h3FF00;

    // Expands 4 byte enables into a 32-bit bit mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{be[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/io_bridge_irq_ctrl.sv
// Interrupt controller: rising-edge latch of raw sources into PENDING,
// per-lane MASK, write-1-to-clear and a registered masked output.
module irq_ctrl
    import io_pkg::*;
#(
    parameter int NUM_IRQ = 16,
    parameter int OFF_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [OFF_W-1:0]   wr_off,
    input  logic [3:0]         wr_be,
    input  logic [31:0]        wr_data,
    input  logic [OFF_W-1:0]   rd_off,
    output logic [31:0]        rd_data,
    input  logic [NUM_IRQ-1:0] irq_src,
    output logic [NUM_IRQ-1:0] irq_out
);

    logic [NUM_IRQ-1:0] src_reg;
    logic [NUM_IRQ-1:0] pending_reg, pending_next;
    logic [NUM_IRQ-1:0] mask_reg, mask_next;
    logic [NUM_IRQ-1:0] irq_out_reg;
    logic [NUM_IRQ-1:0] lane_bits, wr_bits, clr_bits;

    assign lane_bits = NUM_IRQ'(lane_mask(wr_be));
    assign wr_bits   = NUM_IRQ'(wr_data) & lane_bits;
    assign clr_bits  = (wr_en && wr_off == OFF_W'(IRQ_PENDING)) ? wr_bits : '0;

    // A new edge wins over a simultaneous clear so no interrupt is lost.
    assign pending_next = (pending_reg & ~clr_bits) | (irq_src & ~src_reg);
    assign mask_next    = (wr_en && wr_off == OFF_W'(IRQ_MASK)) ?
                          ((mask_reg & ~lane_bits) | wr_bits) : mask_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_reg     <= '0;
            pending_reg <= '0;
            mask_reg    <= '0;
            irq_out_reg <= '0;
        end else begin
            src_reg     <= irq_src;
            pending_reg <= pending_next;
            mask_reg    <= mask_next;
            irq_out_reg <= pending_reg & mask_reg;
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_off == OFF_W'(IRQ_PENDING)) begin
            rd_data = 32'(pending_reg);
        end else if (rd_off == OFF_W'(IRQ_MASK)) begin
            rd_data = 32'(mask_reg);
        end else if (rd_off == OFF_W'(IRQ_RAW)) begin
            rd_data = 32'(irq_src);
        end
    end

    assign irq_out = irq_out_reg;

endmodule

// File: rtl/io_bridge.sv
// Memory-mapped I/O bridge: decodes CPU data-port accesses into main memory,
// NUM_DEV device windows and the interrupt controller, with a 1-cycle read pipe.
module io_bridge
    import io_pkg::*;
#(
    parameter int                ADDR_W     = 18,
    parameter int                NUM_DEV    = 4,
    parameter int                DEV_SPAN_W = 4,
    parameter logic [ADDR_W-1:0] IO_BASE    = ADDR_W'(IO_BASE_DEFAULT),
    parameter int                NUM_IRQ    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_en,
    input  logic [ADDR_W-1:0]     cpu_raddr,
    output logic [31:0]           cpu_rdata,
    input  logic [3:0]            cpu_wen,
    input  logic [ADDR_W-1:0]     cpu_waddr,
    input  logic [31:0]           cpu_wdata,
    output logic [ADDR_W-1:0]     mem_raddr,
    input  logic [31:0]           mem_rdata,
    output logic [3:0]            mem_wen,
    output logic [ADDR_W-1:0]     mem_waddr,
    output logic [31:0]           mem_wdata,
    output logic [NUM_DEV-1:0]    dev_ren,
    output logic [DEV_SPAN_W-1:0] dev_raddr,
    input  logic [NUM_DEV*32-1:0] dev_rdata,
    output logic [NUM_DEV-1:0]    dev_wen,
    output logic [DEV_SPAN_W-1:0] dev_waddr,
    output logic [3:0]            dev_wbe,
    output logic [31:0]           dev_wdata,
    input  logic [NUM_IRQ-1:0]    irq_src,
    output logic [NUM_IRQ-1:0]    irq_out
);

    // The I/O region holds 8 windows; bits above REG_SH identify it.
    localparam int         REG_SH   = DEV_SPAN_W + 3;
    localparam logic [3:0] IRQC_WIN = 4'(NUM_DEV);

    logic                  r_io, w_io, w_any;
    logic [2:0]            r_win, w_win;
    logic [DEV_SPAN_W-1:0] r_off, w_off;
    logic                  irq_wr_en;
    logic [31:0]           irq_rd_data;
    logic [31:0]           dev_word [NUM_DEV];
    logic [31:0]           dev_data;
    rd_sel_e               sel_reg, sel_next;
    logic [31:0]           rdata_reg, rdata_next;

    assign r_io  = (cpu_raddr[ADDR_W-1:REG_SH] == IO_BASE[ADDR_W-1:REG_SH]);
    assign w_io  = (cpu_waddr[ADDR_W-1:REG_SH] == IO_BASE[ADDR_W-1:REG_SH]);
    assign r_win = cpu_raddr[REG_SH-1:DEV_SPAN_W];
    assign w_win = cpu_waddr[REG_SH-1:DEV_SPAN_W];
    assign r_off = cpu_raddr[DEV_SPAN_W-1:0];
    assign w_off = cpu_waddr[DEV_SPAN_W-1:0];
    assign w_any = |cpu_wen;

    assign mem_raddr = cpu_raddr;
    assign mem_waddr = cpu_waddr;
    assign mem_wdata = cpu_wdata;
    assign mem_wen   = w_io ? 4'h0 : cpu_wen;

    assign dev_raddr = r_off;
    assign dev_waddr = w_off;
    assign dev_wbe   = cpu_wen;
    assign dev_wdata = cpu_wdata;

    generate
        for (genvar gi = 0; gi < NUM_DEV; gi++) begin : g_dev
            assign dev_ren[gi]  = clk_en && r_io && (r_win == 3'(gi));
            assign dev_wen[gi]  = clk_en && w_io && (w_win == 3'(gi)) && w_any;
            assign dev_word[gi] = dev_rdata[32*gi +: 32];
        end
    endgenerate

    always_comb begin
        dev_data = '0;
        for (int k = 0; k < NUM_DEV; k++) begin
            if (r_win == 3'(k)) begin
                dev_data = dev_word[k];
            end
        end
    end

    assign irq_wr_en = clk_en && w_io && ({1'b0, w_win} == IRQC_WIN) && w_any;

    irq_ctrl #(
        .NUM_IRQ (NUM_IRQ),
        .OFF_W   (DEV_SPAN_W)
    ) u_irq_ctrl (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (irq_wr_en),
        .wr_off  (w_off),
        .wr_be   (cpu_wen),
        .wr_data (cpu_wdata),
        .rd_off  (r_off),
        .rd_data (irq_rd_data),
        .irq_src (irq_src),
        .irq_out (irq_out)
    );

    always_comb begin
        sel_next   = SEL_MEM;
        rdata_next = '0;
        if (r_io) begin
            if ({1'b0, r_win} < IRQC_WIN) begin
                sel_next   = SEL_DEV;
                rdata_next = dev_data;
            end else if ({1'b0, r_win} == IRQC_WIN) begin
                sel_next   = SEL_IRQC;
                rdata_next = irq_rd_data;
            end else begin
                sel_next   = SEL_NONE;
            end
        end
    end

    // Memory data arrives registered from mem itself, so only the select is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_reg   <= SEL_NONE;
            rdata_reg <= '0;
        end else if (clk_en) begin
            sel_reg   <= sel_next;
            rdata_reg <= rdata_next;
        end
    end

    assign cpu_rdata = (sel_reg == SEL_MEM) ? mem_rdata : rdata_reg;

endmodule

// File: tb/tb_io_bridge.sv
// Self-checking bench for io_bridge: directed scenarios followed by random
// traffic, all checked against an address-map level reference model.
module tb_io_bridge;

    localparam logic [17:0] BASE = 18'h3FF00;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clk_en;
    logic [17:0]  cpu_raddr;
    logic [31:0]  cpu_rdata;
    logic [3:0]   cpu_wen;
    logic [17:0]  cpu_waddr;
    logic [31:0]  cpu_wdata;
    logic [17:0]  mem_raddr;
    logic [31:0]  mem_rdata;
    logic [3:0]   mem_wen;
    logic [17:0]  mem_waddr;
    logic [31:0]  mem_wdata;
    logic [3:0]   dev_ren;
    logic [3:0]   dev_raddr;
    logic [127:0] dev_rdata;
    logic [3:0]   dev_wen;
    logic [3:0]   dev_waddr;
    logic [3:0]   dev_wbe;
    logic [31:0]  dev_wdata;
    logic [15:0]  irq_src;
    logic [15:0]  irq_out;

    logic [31:0]  dev_val [4];
    logic [31:0]  mem [0:1023] = '{default: 32'h0};

    // reference model state
    logic [31:0]  ref_mem [0:1023] = '{default: 32'h0};
    logic [15:0]  m_pend, m_mask, m_srcq, m_irq;
    logic [31:0]  m_rd;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    io_bridge dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_en    (clk_en),
        .cpu_raddr (cpu_raddr),
        .cpu_rdata (cpu_rdata),
        .cpu_wen   (cpu_wen),
        .cpu_waddr (cpu_waddr),
        .cpu_wdata (cpu_wdata),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .mem_wen   (mem_wen),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .dev_ren   (dev_ren),
        .dev_raddr (dev_raddr),
        .dev_rdata (dev_rdata),
        .dev_wen   (dev_wen),
        .dev_waddr (dev_waddr),
        .dev_wbe   (dev_wbe),
        .dev_wdata (dev_wdata),
        .irq_src   (irq_src),
        .irq_out   (irq_out)
    );

    // Main memory: registered read, byte writes, both stalled by clk_en.
    always @(posedge clk) begin
        if (clk_en) begin
            mem_rdata <= mem[mem_raddr[9:0]];
            for (int b = 0; b < 4; b++) begin
                if (mem_wen[b]) mem[mem_waddr[9:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        dev_rdata = '0;
        for (int k = 0; k < 4; k++) dev_rdata[32*k +: 32] = dev_val[k];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void decode(input logic [17:0] a, output bit io, output int win, output int loc);
        int off;
        off = int'(a) - int'(BASE);
        io  = (off >= 0) && (off < 128);
        win = off / 16;
        loc = off % 16;
    endfunction

    function automatic logic [31:0] lanes(input logic [3:0] be);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = be[b] ? 8'hFF : 8'h00;
        return m;
    endfunction

    function automatic logic [31:0] ref_read(input logic [17:0] a, input logic [15:0] src);
        bit io;
        int win, loc;
        decode(a, io, win, loc);
        if (!io) return ref_mem[a[9:0]];
        if (win < 4) return dev_val[win];
        if (win == 4) begin
            case (loc)
                0:       return {16'h0, m_pend};
                1:       return {16'h0, m_mask};
                2:       return {16'h0, src};
                default: return 32'h0;
            endcase
        end
        return 32'h0;
    endfunction

    task automatic model_reset();
        m_pend = '0;
        m_mask = '0;
        m_srcq = '0;
        m_irq  = '0;
        m_rd   = '0;
    endtask

    task automatic cycle(input logic en, input logic [17:0] ra, input logic [3:0] we,
                         input logic [17:0] wa, input logic [31:0] wd, input logic [15:0] src);
        bit          rio, wio;
        int          rwin, rloc, wwin, wloc;
        logic [3:0]  e_ren, e_wen;
        logic [31:0] lm, wm, nxt_rd;
        logic [15:0] clr, rise, nmask;
        @(negedge clk);
        clk_en    = en;
        cpu_raddr = ra;
        cpu_wen   = we;
        cpu_waddr = wa;
        cpu_wdata = wd;
        irq_src   = src;
        #1;
        decode(ra, rio, rwin, rloc);
        decode(wa, wio, wwin, wloc);
        e_ren = (en && rio && rwin < 4) ? 4'(1 << rwin) : 4'h0;
        e_wen = (en && wio && wwin < 4 && we != 4'h0) ? 4'(1 << wwin) : 4'h0;
        check_eq("dev_ren", 32'(dev_ren), 32'(e_ren));
        check_eq("dev_wen", 32'(dev_wen), 32'(e_wen));
        check_eq("mem_wen", 32'(mem_wen), wio ? 32'h0 : 32'(we));
        check_eq("mem_raddr", 32'(mem_raddr), 32'(ra));
        check_eq("mem_waddr", 32'(mem_waddr), 32'(wa));
        if (e_ren != 4'h0) check_eq("dev_raddr", 32'(dev_raddr), 32'(rloc));
        if (e_wen != 4'h0) begin
            check_eq("dev_waddr", 32'(dev_waddr), 32'(wloc));
            check_eq("dev_wbe", 32'(dev_wbe), 32'(we));
            check_eq("dev_wdata", dev_wdata, wd);
        end
        // advance the model by one clock edge
        lm     = lanes(we);
        wm     = wd & lm;
        clr    = '0;
        nmask  = m_mask;
        nxt_rd = m_rd;
        rise   = src & ~m_srcq;
        if (en) begin
            nxt_rd = ref_read(ra, src);
            if (!wio) begin
                for (int b = 0; b < 4; b++)
                    if (we[b]) ref_mem[wa[9:0]][8*b +: 8] = wd[8*b +: 8];
            end else if (wwin == 4 && wloc == 0) begin
                clr = wm[15:0];
            end else if (wwin == 4 && wloc == 1) begin
                nmask = (m_mask & ~lm[15:0]) | wm[15:0];
            end
        end
        m_irq  = m_pend & m_mask;
        m_pend = (m_pend & ~clr) | rise;
        m_mask = nmask;
        m_srcq = src;
        m_rd   = nxt_rd;
        @(posedge clk);
        #1;
        check_eq("cpu_rdata", cpu_rdata, m_rd);
        check_eq("irq_out", 32'(irq_out), 32'(m_irq));
        $display("txn t=%0t en=%0b ra=%h we=%h wa=%h wd=%h src=%h rdata=%h irq=%h",
                 $time, en, ra, we, wa, wd, src, cpu_rdata, irq_out);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst_rdata", cpu_rdata, 32'h0);
        check_eq("rst_irq_out", 32'(irq_out), 32'h0);
        @(posedge clk);
        #1;
        check_eq("rst_rdata_hold", cpu_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [17:0] pick_addr();
        case ($urandom_range(0, 4))
            0:       return 18'($urandom_range(0, 63));
            1:       return BASE + 18'(16 * $urandom_range(0, 3) + $urandom_range(0, 15));
            2:       return BASE + 18'(64 + $urandom_range(0, 3));
            3:       return BASE + 18'(16 * $urandom_range(5, 7) + $urandom_range(0, 15));
            default: return ($urandom_range(0, 1) != 0) ? 18'h3FEFF : 18'h3FF80;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] src;
        rst_n     = 1'b0;
        clk_en    = 1'b1;
        cpu_raddr = '0;
        cpu_wen   = '0;
        cpu_waddr = '0;
        cpu_wdata = '0;
        irq_src   = '0;
        for (int k = 0; k < 4; k++) dev_val[k] = 32'h0;
        model_reset();
        apply_reset();

        // memory write then read back
        cycle(1'b1, 18'h00000, 4'hF, 18'h00010, 32'hDEADBEEF, 16'h0);
        cycle(1'b1, 18'h00010, 4'h0, 18'h00000, 32'h0, 16'h0);
        check_eq("mem_readback", cpu_rdata, 32'hDEADBEEF);

        // device read and write strobes
        dev_val[1] = 32'h00000041;
        cycle(1'b1, 18'h3FF13, 4'h0, 18'h00000, 32'h0, 16'h0);
        check_eq("dev1_read", cpu_rdata, 32'h41);
        cycle(1'b1, 18'h00000, 4'h1, 18'h3FF22, 32'h000000AB, 16'h0);

        // mask, pending and irq_out latency
        cycle(1'b1, 18'h00000, 4'hF, 18'h3FF41, 32'h00000005, 16'h0);
        cycle(1'b1, 18'h00000, 4'h0, 18'h00000, 32'h0, 16'h0003);
        cycle(1'b1, 18'h3FF40, 4'h0, 18'h00000, 32'h0, 16'h0000);
        check_eq("pending_set", cpu_rdata, 32'h3);
        check_eq("irq_out_lat", 32'(irq_out), 32'h1);

        // clear coinciding with a new edge keeps the bit, plain clear drops it
        cycle(1'b1, 18'h00000, 4'hF, 18'h3FF40, 32'h1, 16'h0001);
        cycle(1'b1, 18'h3FF40, 4'h0, 18'h00000, 32'h0, 16'h0001);
        check_eq("w1c_vs_edge", cpu_rdata, 32'h3);
        cycle(1'b1, 18'h00000, 4'h1, 18'h3FF40, 32'h1, 16'h0000);
        cycle(1'b1, 18'h3FF40, 4'h0, 18'h00000, 32'h0, 16'h0000);
        check_eq("w1c_clear", cpu_rdata, 32'h2);
        check_eq("irq_out_drop", 32'(irq_out), 32'h0);

        // stalled read holds, then proceeds
        dev_val[0] = 32'h00001234;
        cycle(1'b0, 18'h3FF01, 4'h0, 18'h00000, 32'h0, 16'h0);
        check_eq("stall_hold", cpu_rdata, 32'h2);
        cycle(1'b1, 18'h3FF01, 4'h0, 18'h00000, 32'h0, 16'h0);
        check_eq("stall_release", cpu_rdata, 32'h1234);

        // reset during a read with PENDING=3
        cycle(1'b1, 18'h00000, 4'h0, 18'h00000, 32'h0, 16'h0001);
        cycle(1'b1, 18'h3FF13, 4'h0, 18'h00000, 32'h0, 16'h0000);
        check_eq("pre_rst_irq", 32'(irq_out), 32'h1);
        apply_reset();
        cycle(1'b1, 18'h3FF40, 4'h0, 18'h00000, 32'h0, 16'h0);
        check_eq("post_rst_pend", cpu_rdata, 32'h0);
        cycle(1'b1, 18'h3FF41, 4'h0, 18'h00000, 32'h0, 16'h0);
        check_eq("post_rst_mask", cpu_rdata, 32'h0);
        cycle(1'b1, 18'h3FF13, 4'h0, 18'h00000, 32'h0, 16'h0);
        cycle(1'b1, 18'h3FF50, 4'hF, 18'h3FF50, 32'hFFFFFFFF, 16'h0);
        check_eq("unmapped_read", cpu_rdata, 32'h0);

        // random traffic
        src = '0;
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 4; k++) dev_val[k] = $urandom;
            if ($urandom_range(0, 3) == 0) src = src ^ (16'($urandom) & 16'($urandom));
            cycle(($urandom_range(0, 4) != 0), pick_addr(),
                  ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
                  pick_addr(), $urandom, src);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
